// File: rtl/v_hier_pkg.sv
// v_hier_pkg: shared state encoding and operand width for the v_hier scheduler
package v_hier_pkg;
    localparam int AW = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/v_hier_rr_pick.sv
// v_hier_rr_pick: combinational round-robin picker starting the search just after ptr
module v_hier_rr_pick #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  id,
    output logic [NREQ-1:0] onehot
);
    logic [IDW-1:0]    sh;
    logic [IDW-1:0]    k;
    logic [IDW:0]      s;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    // rotate the doubled request vector so ptr+1 lands at bit 0, then take the lowest set bit
    always_comb begin
        sh = (ptr == IDW'(NREQ - 1)) ? '0 : ptr + 1'b1;
        dbl = {req, req} >> sh;
        rot = dbl[NREQ-1:0];
        any = |req;
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) k = IDW'(i);
        s = {1'b0, k} + {1'b0, sh};
        id = (s >= (IDW+1)'(NREQ)) ? IDW'(s - (IDW+1)'(NREQ)) : s[IDW-1:0];
        onehot = any ? (NREQ'(1) << id) : '0;
    end
endmodule

// File: rtl/v_hier_sched.sv
// v_hier_sched: round-robin scheduler sharing one v_hier_sub datapath, one transaction in flight
module v_hier_sched
    import v_hier_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] req_avec,
    output logic [NREQ-1:0]  gnt,
    output logic [AW-1:0]    avec,
    input  logic [AW-1:0]    qvec,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [AW-1:0]    rsp_qvec,
    output logic             busy
);
    localparam int CW = $clog2(LAT + 1);

    state_t          state, next_state;
    logic [IDW-1:0]  ptr, id, pick_id;
    logic [CW-1:0]   cnt;
    logic            pick_any;
    logic [NREQ-1:0] pick_onehot;

    v_hier_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .id     (pick_id),
        .onehot (pick_onehot)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // next-state logic: IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = pick_any ? ISSUE : IDLE;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = (cnt == '0) ? RESP : WAIT;
            default: next_state = IDLE;
        endcase
    end

    // outputs: grant only while idle and out of reset, since reset would discard the accept
    always_comb begin
        gnt  = (state == IDLE && rst_n) ? pick_onehot : '0;
        busy = (state != IDLE);
    end

    // datapath: operand capture, latency counter, response registers and priority pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= IDW'(NREQ - 1);
            id        <= '0;
            avec      <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_qvec  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (pick_any) begin
                    id   <= pick_id;
                    avec <= req_avec[int'(pick_id)*AW +: AW];
                end
                ISSUE: cnt <= CW'(LAT - 1);
                WAIT: if (cnt == '0) begin
                    rsp_qvec  <= qvec;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: ptr <= id;
            endcase
        end
    end
endmodule
